// File: rtl/nvdla_csb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_csb_pkg
// Description : Shared constants and types for the NVDLA CSB configuration
//               slave. It holds the decode word addresses, the bit positions
//               of the fields in the 63-bit request packet, and the response
//               packet type.
// Revision    : 1.0 - initial release
// ============================================================================
package nvdla_csb_pkg;

    // Packet widths
    localparam int REQ_PD_W   = 63;
    localparam int RESP_PD_W  = 34;
    localparam int ADDR_DEC_W = 10;   // only addr[9:0] takes part in decode
    localparam int ERR_CNT_W  = 16;

    // Word addresses (addr[9:0])
    localparam logic [ADDR_DEC_W-1:0] ADR_CFG_OS    = 10'h000;
    localparam logic [ADDR_DEC_W-1:0] ADR_STATUS    = 10'h001;
    localparam logic [ADDR_DEC_W-1:0] ADR_ERR_CNT   = 10'h002;
    localparam logic [ADDR_DEC_W-1:0] ADR_RDWT_BASE = 10'h010;
    localparam logic [ADDR_DEC_W-1:0] ADR_WRWT_BASE = 10'h030;

    // Bit field of the write-outstanding count inside CFG_OS
    localparam int OS_WR_LSB = 16;

    // Request packet field positions
    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_ADDR_MSB    = 21;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_LEVEL_LSB   = 61;

    // Response packet {is_wr, error, rdat}
    typedef struct packed {
        logic        is_wr;
        logic        error;
        logic [31:0] rdat;
    } csb_resp_t;

    // Request-processing state
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } csb_state_e;

endpackage
`default_nettype wire

// File: rtl/nvdla_csb_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_csb_cfg_regfile
// Description : Register file behind the CSB slave. It decodes the word
//               address, stores the os-count and weight fields, provides the
//               combinational read mux and flags value changes.
//               Optional feature macro: NVDLA_CSB_ERR_CNT_EN (adds ERR_CNT at
//               word 0x002, a saturating clear-on-read error counter).
// Ports       : nvdla_core_clk / nvdla_core_rstn - clock, async active-low reset
//               addr, wdat       - decoded address and write data of the
//                                  request being processed
//               wr_commit        - commit the write to the decoded field
//               rd_strobe        - a read is being answered this cycle
//               err_inc          - an error/dropped access happens this cycle
//               dp2reg_idle      - datapath idle, shown in STATUS
//               mapped, is_os    - decode results for the current address
//               rdata            - read data (0 for unmapped addresses)
//               rd/wr_os_cnt, rd/wr_weight - field outputs
//               cfg_upd          - one-cycle pulse after a field changes
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_csb_cfg_regfile
    import nvdla_csb_pkg::*;
#(
    parameter int NUM_RD_CH = 12,
    parameter int NUM_WR_CH = 8,
    parameter int REG_W     = 8,
    parameter int WT_RST    = 1,
    parameter int OS_RST    = 255
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    input  logic [ADDR_DEC_W-1:0]         addr,
    input  logic [31:0]                   wdat,
    input  logic                          wr_commit,
    input  logic                          rd_strobe,
    input  logic                          err_inc,
    input  logic                          dp2reg_idle,
    output logic                          mapped,
    output logic                          is_os,
    output logic [31:0]                   rdata,
    output logic [REG_W-1:0]              rd_os_cnt,
    output logic [REG_W-1:0]              wr_os_cnt,
    output logic [NUM_RD_CH*REG_W-1:0]    rd_weight,
    output logic [NUM_WR_CH*REG_W-1:0]    wr_weight,
    output logic                          cfg_upd
);

    localparam logic [REG_W-1:0] WT_RST_V = REG_W'(WT_RST);
    localparam logic [REG_W-1:0] OS_RST_V = REG_W'(OS_RST);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_DEC_W-1:0] rd_off;
    logic [ADDR_DEC_W-1:0] wr_off;
    logic                  hit_os;
    logic                  hit_status;
    logic                  hit_err;
    logic                  hit_rd;
    logic                  hit_wr;

    assign rd_off     = addr - ADR_RDWT_BASE;
    assign wr_off     = addr - ADR_WRWT_BASE;
    assign hit_os     = (addr == ADR_CFG_OS);
    assign hit_status = (addr == ADR_STATUS);
    assign hit_rd     = (addr >= ADR_RDWT_BASE) && (rd_off < ADDR_DEC_W'(NUM_RD_CH));
    assign hit_wr     = (addr >= ADR_WRWT_BASE) && (wr_off < ADDR_DEC_W'(NUM_WR_CH));
    assign mapped     = hit_os | hit_status | hit_err | hit_rd | hit_wr;
    assign is_os      = hit_os;

    // STATUS and ERR_CNT are read-only, so only these three regions write
    logic we_os;
    logic we_rd;
    logic we_wr;

    assign we_os = wr_commit & hit_os;
    assign we_rd = wr_commit & hit_rd;
    assign we_wr = wr_commit & hit_wr;

    logic [REG_W-1:0] new_val;
    logic [REG_W-1:0] new_wr_os;

    assign new_val   = wdat[REG_W-1:0];
    assign new_wr_os = wdat[OS_WR_LSB +: REG_W];

    // ------------------------------------------------------------------
    // Field storage
    // ------------------------------------------------------------------
    logic [REG_W-1:0] rd_wt [NUM_RD_CH];
    logic [REG_W-1:0] wr_wt [NUM_WR_CH];
    logic             changed;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_os_cnt <= OS_RST_V;
            wr_os_cnt <= OS_RST_V;
            for (int i = 0; i < NUM_RD_CH; i++) rd_wt[i] <= WT_RST_V;
            for (int j = 0; j < NUM_WR_CH; j++) wr_wt[j] <= WT_RST_V;
            cfg_upd   <= 1'b0;
        end else begin
            if (we_os) begin
                rd_os_cnt <= new_val;
                wr_os_cnt <= new_wr_os;
            end
            for (int i = 0; i < NUM_RD_CH; i++) begin
                if (we_rd && (rd_off == ADDR_DEC_W'(i))) rd_wt[i] <= new_val;
            end
            for (int j = 0; j < NUM_WR_CH; j++) begin
                if (we_wr && (wr_off == ADDR_DEC_W'(j))) wr_wt[j] <= new_val;
            end
            cfg_upd <= changed;
        end
    end

    // A rewrite of the same value must not disturb the arbiter
    always_comb begin
        changed = 1'b0;
        if (we_os && ((rd_os_cnt != new_val) || (wr_os_cnt != new_wr_os))) changed = 1'b1;
        for (int i = 0; i < NUM_RD_CH; i++) begin
            if (we_rd && (rd_off == ADDR_DEC_W'(i)) && (rd_wt[i] != new_val)) changed = 1'b1;
        end
        for (int j = 0; j < NUM_WR_CH; j++) begin
            if (we_wr && (wr_off == ADDR_DEC_W'(j)) && (wr_wt[j] != new_val)) changed = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD_CH; g++) begin : g_rd_pack
            assign rd_weight[g*REG_W +: REG_W] = rd_wt[g];
        end
        for (g = 0; g < NUM_WR_CH; g++) begin : g_wr_pack
            assign wr_weight[g*REG_W +: REG_W] = wr_wt[g];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional error counter
    // ------------------------------------------------------------------
    logic [31:0] err_rdata;

`ifdef NVDLA_CSB_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr;

    assign hit_err   = (addr == ADR_ERR_CNT);
    assign err_clr   = rd_strobe & hit_err;
    assign err_rdata = {{(32-ERR_CNT_W){1'b0}}, err_cnt};

    // The clearing read wins over a coincident increment
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_err_ports;

    assign hit_err          = 1'b0;
    assign err_rdata        = 32'h0;
    assign unused_err_ports = rd_strobe ^ err_inc;
`endif

    // ------------------------------------------------------------------
    // Read mux; unused bits read as zero
    // ------------------------------------------------------------------
    logic [REG_W-1:0] rd_sel;
    logic [REG_W-1:0] wr_sel;

    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        for (int i = 0; i < NUM_RD_CH; i++) begin
            if (rd_off == ADDR_DEC_W'(i)) rd_sel = rd_wt[i];
        end
        for (int j = 0; j < NUM_WR_CH; j++) begin
            if (wr_off == ADDR_DEC_W'(j)) wr_sel = wr_wt[j];
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (hit_os) begin
            rdata[REG_W-1:0]            = rd_os_cnt;
            rdata[OS_WR_LSB +: REG_W]   = wr_os_cnt;
        end else if (hit_status) begin
            rdata[0] = dp2reg_idle;
        end else if (hit_err) begin
            rdata = err_rdata;
        end else if (hit_rd) begin
            rdata[REG_W-1:0] = rd_sel;
        end else if (hit_wr) begin
            rdata[REG_W-1:0] = wr_sel;
        end
    end

    // Write data bits outside the stored fields are don't-care
    logic unused_wdat;
    assign unused_wdat = ^wdat;

endmodule
`default_nettype wire

// File: rtl/nvdla_csb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_csb_cfg_slave
// Description : CSB register slave for the NVDLA memory-interface arbiter.
//               Holds the request register, the RUN/WAIT state machine that
//               defers outstanding-count writes until the datapath is idle
//               (with timeout), and the registered response. Field storage
//               and decode live in nvdla_csb_cfg_regfile.
//               Optional feature macro: NVDLA_CSB_ERR_CNT_EN.
// Ports       : nvdla_core_clk / nvdla_core_rstn - clock, async active-low reset
//               csb_req_pvld/prdy/pd   - request channel (63-bit packet)
//               csb_resp_valid/pd      - response channel (34-bit packet)
//               dp2reg_idle            - datapath idle
//               reg2dp_*               - configuration outputs to the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_csb_cfg_slave
    import nvdla_csb_pkg::*;
#(
    parameter int NUM_RD_CH = 12,
    parameter int NUM_WR_CH = 8,
    parameter int REG_W     = 8,
    parameter int WT_RST    = 1,
    parameter int OS_RST    = 255,
    parameter int TMO_W     = 10
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    input  logic                          csb_req_pvld,
    output logic                          csb_req_prdy,
    input  logic [REQ_PD_W-1:0]           csb_req_pd,
    output logic                          csb_resp_valid,
    output logic [RESP_PD_W-1:0]          csb_resp_pd,
    input  logic                          dp2reg_idle,
    output logic [REG_W-1:0]              reg2dp_rd_os_cnt,
    output logic [REG_W-1:0]              reg2dp_wr_os_cnt,
    output logic [NUM_RD_CH*REG_W-1:0]    reg2dp_rd_weight,
    output logic [NUM_WR_CH*REG_W-1:0]    reg2dp_wr_weight,
    output logic                          reg2dp_cfg_upd
);

    // ------------------------------------------------------------------
    // Request register
    // ------------------------------------------------------------------
    logic                  req_vld;
    logic [REQ_PD_W-1:0]   req_pd;
    logic                  req_write;
    logic                  req_nposted;
    logic [ADDR_DEC_W-1:0] req_addr;
    logic [31:0]           req_wdat;

    assign req_write   = req_pd[REQ_WRITE_BIT];
    assign req_nposted = req_pd[REQ_NPOSTED_BIT];
    assign req_addr    = req_pd[REQ_ADDR_LSB +: ADDR_DEC_W];
    assign req_wdat    = req_pd[REQ_WDAT_LSB +: 32];

    // level, wrbe, srcpriv and the upper address bits do not affect behaviour
    logic unused_req_bits;
    assign unused_req_bits = ^{req_pd[REQ_PD_W-1:REQ_SRCPRIV_BIT],
                               req_pd[REQ_ADDR_MSB:ADDR_DEC_W]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic        mapped;
    logic        is_os;
    logic [31:0] rdata;
    logic        commit;
    logic        rd_strobe;
    logic        err_inc;

    nvdla_csb_cfg_regfile #(
        .NUM_RD_CH (NUM_RD_CH),
        .NUM_WR_CH (NUM_WR_CH),
        .REG_W     (REG_W),
        .WT_RST    (WT_RST),
        .OS_RST    (OS_RST)
    ) u_regfile (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .addr            (req_addr),
        .wdat            (req_wdat),
        .wr_commit       (commit),
        .rd_strobe       (rd_strobe),
        .err_inc         (err_inc),
        .dp2reg_idle     (dp2reg_idle),
        .mapped          (mapped),
        .is_os           (is_os),
        .rdata           (rdata),
        .rd_os_cnt       (reg2dp_rd_os_cnt),
        .wr_os_cnt       (reg2dp_wr_os_cnt),
        .rd_weight       (reg2dp_rd_weight),
        .wr_weight       (reg2dp_wr_weight),
        .cfg_upd         (reg2dp_cfg_upd)
    );

    // ------------------------------------------------------------------
    // RUN/WAIT state machine
    // ------------------------------------------------------------------
    csb_state_e  state;
    csb_state_e  state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic        hold;          // keep the request register occupied
    logic        resp_vld_nxt;
    csb_resp_t   resp_nxt;

    always_comb begin
        state_nxt    = state;
        tmo_cnt_nxt  = tmo_cnt;
        hold         = 1'b0;
        commit       = 1'b0;
        rd_strobe    = 1'b0;
        err_inc      = 1'b0;
        resp_vld_nxt = 1'b0;
        resp_nxt     = '0;

        case (state)
            ST_RUN: begin
                if (req_vld) begin
                    if (req_write && is_os && !dp2reg_idle) begin
                        // Outstanding limits may only change with the datapath idle
                        state_nxt   = ST_WAIT;
                        hold        = 1'b1;
                        tmo_cnt_nxt = '0;
                    end else if (req_write) begin
                        commit         = mapped;
                        err_inc        = !mapped;
                        resp_vld_nxt   = req_nposted;
                        resp_nxt.is_wr = 1'b1;
                        resp_nxt.error = !mapped;
                    end else begin
                        rd_strobe      = 1'b1;
                        err_inc        = !mapped;
                        resp_vld_nxt   = 1'b1;
                        resp_nxt.error = !mapped;
                        resp_nxt.rdat  = rdata;
                    end
                end
            end
            ST_WAIT: begin
                resp_nxt.is_wr = 1'b1;
                if (dp2reg_idle) begin
                    // Idle takes priority over a coincident timeout
                    commit       = 1'b1;
                    resp_vld_nxt = req_nposted;
                    state_nxt    = ST_RUN;
                    tmo_cnt_nxt  = '0;
                end else if (tmo_cnt == {TMO_W{1'b1}}) begin
                    err_inc        = 1'b1;
                    resp_vld_nxt   = req_nposted;
                    resp_nxt.error = 1'b1;
                    state_nxt      = ST_RUN;
                    tmo_cnt_nxt    = '0;
                end else begin
                    hold        = 1'b1;
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (!resp_vld_nxt) resp_nxt = '0;
    end

    // Ready drops in the very cycle a stall is detected, so no second
    // request can overwrite the held one
    assign csb_req_prdy = (state == ST_RUN) && !hold;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_vld        <= 1'b0;
            req_pd         <= '0;
            state          <= ST_RUN;
            tmo_cnt        <= '0;
            csb_resp_valid <= 1'b0;
            csb_resp_pd    <= '0;
        end else begin
            if (csb_req_pvld && csb_req_prdy) begin
                req_vld <= 1'b1;
                req_pd  <= csb_req_pd;
            end else if (!hold) begin
                req_vld <= 1'b0;
            end
            state          <= state_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            csb_resp_valid <= resp_vld_nxt;
            csb_resp_pd    <= resp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nvdla_csb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvdla_csb_cfg_slave
// Description : Self-checking bench for nvdla_csb_cfg_slave. Directed cases
//               followed by randomized single transactions, a back-to-back
//               read burst and a reset during a deferred write, all checked
//               against a transaction-level model of the register map.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nvdla_csb_cfg_slave;

    localparam int NUM_RD_CH = 12;
    localparam int NUM_WR_CH = 8;
    localparam int REG_W     = 8;
    localparam int WT_RST    = 1;
    localparam int OS_RST    = 255;
    localparam int TMO_W     = 4;
    localparam int TMO_MAX   = (1 << TMO_W) - 1;
`ifdef NVDLA_CSB_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       pvld = 1'b0;
    logic                       prdy;
    logic [62:0]                req_pd = '0;
    logic                       resp_valid;
    logic [33:0]                resp_pd;
    logic                       idle = 1'b1;
    logic [REG_W-1:0]           rd_os;
    logic [REG_W-1:0]           wr_os;
    logic [NUM_RD_CH*REG_W-1:0] rd_wt_o;
    logic [NUM_WR_CH*REG_W-1:0] wr_wt_o;
    logic                       cfg_upd;

    always #5 clk = ~clk;

    nvdla_csb_cfg_slave #(
        .NUM_RD_CH (NUM_RD_CH),
        .NUM_WR_CH (NUM_WR_CH),
        .REG_W     (REG_W),
        .WT_RST    (WT_RST),
        .OS_RST    (OS_RST),
        .TMO_W     (TMO_W)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .csb_req_pvld     (pvld),
        .csb_req_prdy     (prdy),
        .csb_req_pd       (req_pd),
        .csb_resp_valid   (resp_valid),
        .csb_resp_pd      (resp_pd),
        .dp2reg_idle      (idle),
        .reg2dp_rd_os_cnt (rd_os),
        .reg2dp_wr_os_cnt (wr_os),
        .reg2dp_rd_weight (rd_wt_o),
        .reg2dp_wr_weight (wr_wt_o),
        .reg2dp_cfg_upd   (cfg_upd)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Register-map model
    // ------------------------------------------------------------------
    int m_rd [NUM_RD_CH];
    int m_wr [NUM_WR_CH];
    int m_rd_os;
    int m_wr_os;
    int m_err;

    task automatic model_reset();
        for (int i = 0; i < NUM_RD_CH; i++) m_rd[i] = WT_RST % (1 << REG_W);
        for (int j = 0; j < NUM_WR_CH; j++) m_wr[j] = WT_RST % (1 << REG_W);
        m_rd_os = OS_RST % (1 << REG_W);
        m_wr_os = OS_RST % (1 << REG_W);
        m_err   = 0;
    endtask

    function automatic bit is_mapped(input int a);
        return (a == 0) || (a == 1) || (ERR_EN && a == 2) ||
               (a >= 16 && a < 16 + NUM_RD_CH) || (a >= 48 && a < 48 + NUM_WR_CH);
    endfunction

    function automatic int read_val(input int a, input bit idl);
        if (a == 0) return m_wr_os * 65536 + m_rd_os;
        if (a == 1) return int'(idl);
        if (ERR_EN && a == 2) return m_err;
        if (a >= 16 && a < 16 + NUM_RD_CH) return m_rd[a - 16];
        if (a >= 48 && a < 48 + NUM_WR_CH) return m_wr[a - 48];
        return 0;
    endfunction

    task automatic check_outputs();
        logic [127:0] er;
        logic [127:0] ew;
        er = '0;
        ew = '0;
        for (int i = 0; i < NUM_RD_CH; i++) er[i*REG_W +: REG_W] = REG_W'(m_rd[i]);
        for (int j = 0; j < NUM_WR_CH; j++) ew[j*REG_W +: REG_W] = REG_W'(m_wr[j]);
        check_val("rd_os_cnt", 128'(rd_os), 128'(m_rd_os));
        check_val("wr_os_cnt", 128'(wr_os), 128'(m_wr_os));
        check_val("rd_weight", 128'(rd_wt_o), er);
        check_val("wr_weight", 128'(wr_wt_o), ew);
    endtask

    // One request presented alone. m>0 on a CFG_OS write holds idle low and
    // raises it m cycles after the request reaches the slave.
    task automatic xact(input bit wr, input bit np, input logic [9:0] a,
                        input logic [31:0] d, input int m);
        bit          stall, mapped, tmo, commit, changed, exp_vld;
        logic [33:0] exp_pd;
        logic [31:0] rv;
        int          lat, ai;
        ai     = int'(a);
        mapped = is_mapped(ai);
        stall  = wr && (a == 10'h000) && (m > 0);
        @(negedge clk);
        check_val("cfg_upd_quiet", 128'(cfg_upd), 128'(0));
        check_val("prdy_free", 128'(prdy), 128'(1));
        pvld   = 1'b1;
        req_pd = {2'($urandom), 4'($urandom), 1'($urandom), np, wr, d, 12'($urandom), a};
        if (stall) idle = 1'b0;
        else if (wr && a == 10'h000) idle = 1'b1;
        else idle = 1'($urandom);
        rv = 32'(read_val(ai, idle));
        @(negedge clk);
        pvld   = 1'b0;
        req_pd = 63'({$urandom, $urandom});
        check_val("resp_t1", 128'(resp_valid), 128'(0));
        tmo = 1'b0;
        if (stall) begin
            check_val("prdy_stall", 128'(prdy), 128'(0));
            if (m - 1 <= TMO_MAX) lat = m;
            else begin
                lat = TMO_MAX + 1;
                tmo = 1'b1;
            end
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (c == m) idle = 1'b1;
                check_val("prdy_wait", 128'(prdy), 128'(0));
                check_val("resp_wait", 128'(resp_valid), 128'(0));
            end
        end
        commit  = wr && mapped && !tmo && (a != 10'h001) && (a != 10'h002);
        exp_vld = !wr || np;
        exp_pd  = {wr, (!mapped || tmo), (wr ? 32'h0 : rv)};
        if (ERR_EN && !wr && a == 10'h002) m_err = 0;
        else if ((!mapped || tmo) && m_err < 65535) m_err++;
        changed = 1'b0;
        if (commit) begin
            if (ai == 0) begin
                changed = (m_rd_os != int'(d[REG_W-1:0])) || (m_wr_os != int'(d[16 +: REG_W]));
                m_rd_os = int'(d[REG_W-1:0]);
                m_wr_os = int'(d[16 +: REG_W]);
            end else if (ai >= 16 && ai < 16 + NUM_RD_CH) begin
                changed = m_rd[ai - 16] != int'(d[REG_W-1:0]);
                m_rd[ai - 16] = int'(d[REG_W-1:0]);
            end else begin
                changed = m_wr[ai - 48] != int'(d[REG_W-1:0]);
                m_wr[ai - 48] = int'(d[REG_W-1:0]);
            end
        end
        @(negedge clk);
        check_val("resp_valid", 128'(resp_valid), 128'(exp_vld));
        if (exp_vld) check_val("resp_pd", 128'(resp_pd), 128'(exp_pd));
        check_val("cfg_upd", 128'(cfg_upd), 128'(changed));
        check_outputs();
        idle = 1'b1;
    endtask

    // Back-to-back reads of mapped fields: one response per cycle, two later
    task automatic burst_reads(input int n);
        logic [33:0] expq [$];
        logic [9:0]  a;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check_val("burst_valid", 128'(resp_valid), 128'(1));
                check_val("burst_pd", 128'(resp_pd), 128'(expq.pop_front()));
            end
            if (c < n) begin
                check_val("burst_prdy", 128'(prdy), 128'(1));
                case ($urandom_range(0, 2))
                    0:       a = 10'h000;
                    1:       a = 10'h010 + 10'($urandom_range(0, NUM_RD_CH - 1));
                    default: a = 10'h030 + 10'($urandom_range(0, NUM_WR_CH - 1));
                endcase
                pvld   = 1'b1;
                req_pd = {9'($urandom), 1'b0, 32'($urandom), 12'($urandom), a};
                expq.push_back({2'b00, 32'(read_val(int'(a), idle))});
            end else begin
                pvld = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        bit          w;
        bit          np;
        int          m;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_resp_valid", 128'(resp_valid), 128'(0));
        check_val("rst_resp_pd", 128'(resp_pd), 128'(0));
        check_val("rst_cfg_upd", 128'(cfg_upd), 128'(0));
        check_val("rst_prdy", 128'(prdy), 128'(1));
        check_outputs();

        // Directed cases
        xact(1'b0, 1'b0, 10'h000, 32'h0, 0);
        xact(1'b0, 1'b0, 10'h012, 32'h0, 0);
        xact(1'b1, 1'b1, 10'h015, 32'h0000_00A5, 0);
        xact(1'b1, 1'b1, 10'h015, 32'h0000_00A5, 0);
        xact(1'b0, 1'b0, 10'h050, 32'h0, 0);
        xact(1'b1, 1'b0, 10'h3FF, 32'hDEAD_BEEF, 0);
        xact(1'b1, 1'b1, 10'h001, 32'hFFFF_FFFF, 0);
        xact(1'b1, 1'b1, 10'h000, 32'h0020_0010, 6);
        xact(1'b1, 1'b1, 10'h000, 32'h0030_0040, 100);
        xact(1'b1, 1'b1, 10'h000, 32'h0030_0040, TMO_MAX + 1);
        xact(1'b1, 1'b0, 10'h000, 32'h0011_0022, 100);
        xact(1'b0, 1'b0, 10'h002, 32'h0, 0);
        for (int k = 0; k < 3; k++) xact(1'b0, 1'b0, 10'h3A0, 32'h0, 0);
        xact(1'b0, 1'b0, 10'h002, 32'h0, 0);
        xact(1'b0, 1'b0, 10'h002, 32'h0, 0);

        burst_reads(10);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 10'h000;
                1:       a = 10'h001;
                2:       a = 10'h002;
                3, 4:    a = 10'h010 + 10'($urandom_range(0, 15));
                5, 6:    a = 10'h030 + 10'($urandom_range(0, 15));
                7:       a = 10'($urandom);
                8:       a = 10'h010 + 10'($urandom_range(0, NUM_RD_CH - 1));
                default: a = 10'h030 + 10'($urandom_range(0, NUM_WR_CH - 1));
            endcase
            w  = 1'($urandom);
            np = 1'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 3) == 0) d = 32'(read_val(int'(a), 1'b1));
            m  = (w && a == 10'h000 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            xact(w, np, a, d, m);
        end

        burst_reads(6);

        // Reset while a CFG_OS write waits for idle: the write is discarded
        xact(1'b1, 1'b1, 10'h000, 32'h0044_0033, 0);
        @(negedge clk);
        pvld   = 1'b1;
        req_pd = {9'b0_0000_0010 | 9'h002, 1'b1, 32'h0055_0066, 22'h0};
        req_pd[55] = 1'b1;
        req_pd[54] = 1'b1;
        idle   = 1'b0;
        @(negedge clk);
        pvld   = 1'b0;
        check_val("prdy_pre_rst", 128'(prdy), 128'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        check_val("rst_mid_resp", 128'(resp_valid), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        idle = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("rst_no_resp", 128'(resp_valid), 128'(0));
        end
        check_val("rst_prdy_back", 128'(prdy), 128'(1));
        check_outputs();
        xact(1'b0, 1'b0, 10'h000, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
